mem_port_arbiter: RTL

- Shares one single-port synchronous SRAM macro (1RW, one-cycle read latency) between two requesters: the core data/fetch port and the UART Wishbone bridge.
- Replaces the static i_select_mem muxing with a real arbiter. The core stalls whenever it loses arbitration.
- A burst limiter stops a streaming UART load from starving the core indefinitely.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one 1RW single-cycle-latency SRAM between the core port and the UART Wishbone bridge.
// Optional MEM_ARB_PERF_EN adds saturating stall-cycle and UART-transfer counters.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int UART_MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_req_i,
  input  logic                    core_we_i,
  input  logic [ADDR_WIDTH-1:0]   core_adr_i,
  input  logic [DATA_WIDTH-1:0]   core_dat_i,
  input  logic [DATA_WIDTH/8-1:0] core_wmask_i,
  output logic                    core_stall_o,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_dat_o,
  input  logic                    uart_cyc_i,
  input  logic                    uart_stb_i,
  input  logic                    uart_we_i,
  input  logic [ADDR_WIDTH-1:0]   uart_adr_i,
  input  logic [DATA_WIDTH-1:0]   uart_dat_i,
  output logic                    uart_ack_o,
  output logic [DATA_WIDTH-1:0]   uart_dat_o,
  output logic                    sram_csb_o,
  output logic                    sram_web_o,
  output logic [DATA_WIDTH/8-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_din_o,
  input  logic [DATA_WIDTH-1:0]   sram_dout_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt_o,
  output logic [31:0]             perf_uart_xfer_cnt_o
`endif
);

  localparam int BW = $clog2(UART_MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(UART_MAX_BURST);

  typedef enum logic [1:0] {IDLE, CORE_RD, UART_ACK} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            uart_rd_q, uart_rd_d;

  logic in_idle, uart_req, gnt_uart, gnt_core;

  assign in_idle  = (state_q == IDLE);
  assign uart_req = uart_cyc_i & uart_stb_i;
  assign gnt_uart = in_idle & uart_req & (~core_req_i | (burst_q < MAX_B));
  assign gnt_core = in_idle & core_req_i & ~gnt_uart;

  always_comb begin
    state_d   = IDLE;
    burst_d   = burst_q;
    uart_rd_d = uart_rd_q;
    if (in_idle) begin
      if (gnt_uart) begin
        state_d   = UART_ACK;
        uart_rd_d = ~uart_we_i;
      end else if (gnt_core && !core_we_i) begin
        state_d = CORE_RD;
      end
      // Only UART wins that happen while the core waits count toward the burst limit.
      if (gnt_core || !core_req_i)
        burst_d = '0;
      else if (gnt_uart && burst_q != MAX_B)
        burst_d = burst_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      uart_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      uart_rd_q <= uart_rd_d;
    end
  end

  // Outputs are gated by rst_n so the SRAM and both masters see a quiet bus during reset.
  always_comb begin
    sram_csb_o   = ~rst_n | ~(gnt_uart | gnt_core);
    sram_web_o   = 1'b1;
    if (rst_n && gnt_uart)
      sram_web_o = ~uart_we_i;
    else if (rst_n && gnt_core)
      sram_web_o = ~core_we_i;
    sram_wmask_o = gnt_uart ? '1 : core_wmask_i;
    sram_addr_o  = gnt_uart ? uart_adr_i : core_adr_i;
    sram_din_o   = gnt_uart ? uart_dat_i : core_dat_i;
  end

  assign core_rvalid_o = rst_n & (state_q == CORE_RD);
  assign core_dat_o    = core_rvalid_o ? sram_dout_i : '0;
  assign uart_ack_o    = rst_n & (state_q == UART_ACK);
  assign uart_dat_o    = (uart_ack_o & uart_rd_q) ? sram_dout_i : '0;
  assign core_stall_o  = rst_n & core_req_i &
                         ((state_q == UART_ACK) | (in_idle & ~(gnt_core & core_we_i)));

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_o     <= '0;
      perf_uart_xfer_cnt_o <= '0;
    end else begin
      if (core_stall_o && perf_stall_cnt_o != '1)
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (uart_ack_o && perf_uart_xfer_cnt_o != '1)
        perf_uart_xfer_cnt_o <= perf_uart_xfer_cnt_o + 32'd1;
    end
  end
`endif

endmodule
